// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - reorder buffer controller: head/tail pointers, done bits, one-cycle flush recovery
module rob_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_ready,
  output logic [AW-1:0] alloc_addr,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  output logic          commit_ready,
  output logic [AW-1:0] commit_addr,
  input  logic          commit_ack,
  input  logic          flush_req,
  input  logic [AW-1:0] flush_addr,
  output logic          flush_busy,
  output logic [AW:0]   count,
  input  logic [AW-1:0] query_addr,
  output logic          query_valid
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t           r_state;
  logic [AW:0]      r_head;
  logic [AW:0]      r_tail;
  logic [DEPTH-1:0] r_done;

  logic             w_empty;
  logic             w_full;
  logic [AW:0]      w_count;
  logic [AW-1:0]    w_wb_off;
  logic [AW-1:0]    w_fl_off;
  logic [AW-1:0]    w_q_off;
  logic             w_wb_in;
  logic             w_fl_in;
  logic             w_alloc_fire;
  logic             w_commit_fire;
  logic             w_flush_fire;
  logic             w_wb_squashed;
  logic [AW:0]      w_flush_tail;
  logic [DEPTH-1:0] w_done_nxt;

  // Age of an address relative to head; an address is live when its age is below count.
  function automatic logic [AW-1:0] f_age(input logic [AW-1:0] a, input logic [AW-1:0] h);
    return a - h;
  endfunction

  assign w_count  = r_tail - r_head;
  assign w_empty  = (r_head == r_tail);
  assign w_full   = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

  assign w_wb_off = f_age(wb_addr, r_head[AW-1:0]);
  assign w_fl_off = f_age(flush_addr, r_head[AW-1:0]);
  assign w_q_off  = f_age(query_addr, r_head[AW-1:0]);
  assign w_wb_in  = ({1'b0, w_wb_off} < w_count);
  assign w_fl_in  = ({1'b0, w_fl_off} < w_count);

  assign alloc_ready   = !w_full && (r_state == S_RUN) && !flush_req;
  assign commit_ready  = !w_empty && r_done[r_head[AW-1:0]];
  assign w_alloc_fire  = alloc_req && alloc_ready;
  assign w_commit_fire = commit_ack && commit_ready;
  assign w_flush_fire  = flush_req && w_fl_in && (r_state == S_RUN);
  assign w_wb_squashed = w_flush_fire && (w_wb_off > w_fl_off);
  assign w_flush_tail  = r_head + {1'b0, w_fl_off} + (AW+1)'(1);

  assign alloc_addr  = r_tail[AW-1:0];
  assign commit_addr = r_head[AW-1:0];
  assign flush_busy  = (r_state == S_FLUSH);
  assign count       = w_count;
  assign query_valid = ({1'b0, w_q_off} < w_count);

  always_comb begin
    w_done_nxt = r_done;
    if (wb_valid && w_wb_in && !w_wb_squashed)
      w_done_nxt[wb_addr] = 1'b1;
    if (w_flush_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (f_age(AW'(i), r_head[AW-1:0]) > w_fl_off)
          w_done_nxt[i] = 1'b0;
      end
    end
    if (w_commit_fire)
      w_done_nxt[r_head[AW-1:0]] = 1'b0;
    if (w_alloc_fire)
      w_done_nxt[r_tail[AW-1:0]] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_done  <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (w_commit_fire)
        r_head <= r_head + (AW+1)'(1);
      case (r_state)
        S_RUN: begin
          if (w_flush_fire) begin
            r_tail  <= w_flush_tail;
            r_state <= S_FLUSH;
          end else if (w_alloc_fire) begin
            r_tail <= r_tail + (AW+1)'(1);
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
